// File: rtl/mem_access_unit.sv
// Memory access unit: turns pipeline load/store requests into word-wide mainmem cycles.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Highest word-aligned address that still lies inside mainmem.
    localparam logic [31:0] LAST_WORD = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      state_q, state_d;

    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_data_in_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;

    logic        accept;
    logic        req_error;
    logic [31:0] addr_aligned;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign accept = req_valid && req_ready;

    // Classify the incoming request: illegal size, misalignment or out of range.
    always_comb begin
        addr_aligned = {req_addr[31:2], 2'b00};
        req_error    = 1'b0;
        case (req_size)
            SIZE_BYTE: req_error = 1'b0;
            SIZE_HALF: req_error = req_addr[0];
            SIZE_WORD: req_error = |req_addr[1:0];
            default:   req_error = 1'b1;
        endcase
        if ((req_addr < STARTING_ADDR) || (addr_aligned > LAST_WORD)) begin
            req_error = 1'b1;
        end
    end

    // Extract and extend the addressed lane of the fetched word for loads.
    always_comb begin
        byte_val  = mem_data_out[{offset_q, 3'b000} +: 8];
        half_val  = mem_data_out[{offset_q[1], 4'b0000} +: 16];
        load_data = mem_data_out;
        case (size_q)
            SIZE_BYTE: load_data = {{24{~unsigned_q & byte_val[7]}}, byte_val};
            SIZE_HALF: load_data = {{16{~unsigned_q & half_val[15]}}, half_val};
            default:   load_data = mem_data_out;
        endcase
    end

    // Merge store data into the fetched word; untouched lanes pass through.
    always_comb begin
        store_data = mem_data_out;
        for (int i = 0; i < 4; i++) begin
            if ((size_q == SIZE_BYTE) && (offset_q == i[1:0])) begin
                store_data[8*i +: 8] = wdata_q[7:0];
            end else if ((size_q == SIZE_HALF) && (offset_q[1] == i[1])) begin
                store_data[8*i +: 8] = i[0] ? wdata_q[15:8] : wdata_q[7:0];
            end
        end
    end

    // State register; reset overrides any accept or handshake in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_error) begin
                        state_d = StResp;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:   state_d = write_q ? StWr : StResp;
            StWr:   state_d = StResp;
            StResp: if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; reset forces handshake and write strobe low.
    always_comb begin
        req_ready      = (state_q == StIdle) && !reset;
        mem_read_write = (state_q == StWr) && !reset;
        resp_valid     = (state_q == StResp);
        resp_rdata     = resp_rdata_q;
        resp_error     = resp_error_q;
        mem_address    = mem_address_q;
        mem_data_in    = mem_data_in_q;
    end

    // Request latch and datapath registers; address/data hold outside RD/WR.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q       <= 1'b0;
            size_q        <= 2'b00;
            unsigned_q    <= 1'b0;
            offset_q      <= 2'b00;
            wdata_q       <= 16'h0;
            mem_address_q <= STARTING_ADDR;
            mem_data_in_q <= 32'h0;
            resp_rdata_q  <= 32'h0;
            resp_error_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        write_q      <= req_write;
                        size_q       <= req_size;
                        unsigned_q   <= req_unsigned;
                        offset_q     <= req_addr[1:0];
                        wdata_q      <= req_wdata[15:0];
                        resp_error_q <= req_error;
                        resp_rdata_q <= 32'h0;
                        if (!req_error) begin
                            mem_address_q <= addr_aligned;
                        end
                        if (!req_error && req_write && (req_size == SIZE_WORD)) begin
                            mem_data_in_q <= req_wdata;
                        end
                    end
                end
                StRd: begin
                    if (write_q) begin
                        mem_data_in_q <= store_data;
                    end else begin
                        resp_rdata_q <= load_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small behavioural mainmem.
module tb_mem_access_unit;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          w0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    logic        prev_valid = 1'b0;
    logic        mem_inited = 1'b0;
    string       cur_test = "init";

    // 16 words at 0x01000000 plus the top word of the range.
    logic [31:0] mem_words [0:15];
    logic [31:0] top_word;

    always_comb begin
        if (mem_address[31:6] == 26'h0040000) mem_data_out = mem_words[mem_address[5:2]];
        else if (mem_address == 32'h010F_FFFC) mem_data_out = top_word;
        else mem_data_out = 32'hDEAD_BEEF;
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!mem_inited) begin
            for (int i = 0; i < 16; i++) mem_words[i] <= 32'h0;
            mem_words[1] <= 32'h80FF_7F01;
            mem_words[2] <= 32'h1122_3344;
            top_word     <= 32'hCAFE_F00D;
            mem_inited   <= 1'b1;
        end else if (mem_read_write) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_address;
            last_wr_data <= mem_data_in;
            if (mem_address[31:6] == 26'h0040000) mem_words[mem_address[5:2]] <= mem_data_in;
            else if (mem_address == 32'h010F_FFFC) top_word <= mem_data_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [%s] %s: got %h expected %h", cur_test, name, act, exp);
        end
    endtask

    // Monitor: compare each new response against the head of the scoreboard.
    always @(negedge clock) begin
        if (resp_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL [%s] unexpected_resp: got rdata %h err %b, expected none",
                         cur_test, resp_rdata, resp_error);
            end else begin
                mon_e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_error", {31'b0, resp_error}, {31'b0, mon_e.err});
                chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
            end
        end
        prev_valid = resp_valid;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL [%s] ready_timeout: got req_ready 0 expected 1", cur_test);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input logic push);
        exp_t e;
        wait_ready();
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clock);
        #1;
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = exp_lat;
            e.acc   = cyc;
            sb_q.push_back(e);
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clock);
        while ((sb_q.size() != 0 || resp_valid) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0 || resp_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL [%s] resp_timeout: got %0d pending expected 0", cur_test, sb_q.size());
        end
    endtask

    task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        issue(wr, sz, uns, addr, wdata, exp_rdata, exp_err, exp_lat, 1'b1);
        drain();
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b1;

        cur_test = "reset";
        repeat (3) @(negedge clock);
        chk("resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("req_ready_in_reset", {31'b0, req_ready}, 32'h0);
        chk("mem_address", mem_address, 32'h0100_0000);
        chk("mem_data_in", mem_data_in, 32'h0);
        chk("resp_rdata", resp_rdata, 32'h0);
        chk("mem_read_write", {31'b0, mem_read_write}, 32'h0);
        reset = 1'b0;
        #1;
        chk("req_ready_after_reset", {31'b0, req_ready}, 32'h1);

        cur_test = "loads";
        txn(0, SZ_B, 0, 32'h0100_0006, 0, 32'hFFFF_FFFF, 0, 2);
        txn(0, SZ_H, 1, 32'h0100_0006, 0, 32'h0000_80FF, 0, 2);
        txn(0, SZ_W, 0, 32'h0100_0004, 0, 32'h80FF_7F01, 0, 2);
        txn(0, SZ_B, 1, 32'h0100_0007, 0, 32'h0000_0080, 0, 2);
        txn(0, SZ_H, 0, 32'h0100_0004, 0, 32'h0000_7F01, 0, 2);
        txn(0, SZ_H, 0, 32'h0100_0006, 0, 32'hFFFF_80FF, 0, 2);
        txn(0, SZ_B, 0, 32'h0100_0004, 0, 32'h0000_0001, 0, 2);

        cur_test = "store_byte";
        w0 = wr_count;
        txn(1, SZ_B, 0, 32'h0100_0005, 32'hFFFF_FFAB, 32'h0, 0, 3);
        chk("write_count", wr_count - w0, 32'd1);
        chk("write_addr", last_wr_addr, 32'h0100_0004);
        chk("write_data", last_wr_data, 32'h80FF_AB01);
        txn(0, SZ_W, 0, 32'h0100_0004, 0, 32'h80FF_AB01, 0, 2);

        cur_test = "store_half";
        w0 = wr_count;
        txn(1, SZ_H, 0, 32'h0100_000A, 32'h1234_BEEF, 32'h0, 0, 3);
        chk("write_count", wr_count - w0, 32'd1);
        chk("write_data", last_wr_data, 32'hBEEF_3344);

        cur_test = "store_word";
        w0 = wr_count;
        txn(1, SZ_W, 0, 32'h0100_000C, 32'hA5A5_5A5A, 32'h0, 0, 2);
        chk("write_count", wr_count - w0, 32'd1);
        chk("write_addr", last_wr_addr, 32'h0100_000C);
        txn(0, SZ_W, 0, 32'h0100_000C, 0, 32'hA5A5_5A5A, 0, 2);

        cur_test = "errors";
        w0 = wr_count;
        txn(0, SZ_W, 0, 32'h0100_0002, 0, 32'h0, 1, 1);
        txn(0, SZ_W, 0, 32'h00FF_FFFC, 0, 32'h0, 1, 1);
        txn(0, SZ_X, 0, 32'h0100_0004, 0, 32'h0, 1, 1);
        txn(0, SZ_H, 1, 32'h0100_0001, 0, 32'h0, 1, 1);
        txn(0, SZ_B, 0, 32'h0110_0000, 0, 32'h0, 1, 1);
        txn(1, SZ_W, 0, 32'h0100_0006, 32'h1111_1111, 32'h0, 1, 1);
        chk("no_writes_on_error", wr_count - w0, 32'd0);

        cur_test = "top_word";
        txn(0, SZ_W, 0, 32'h010F_FFFC, 0, 32'hCAFE_F00D, 0, 2);
        txn(0, SZ_B, 0, 32'h010F_FFFF, 0, 32'hFFFF_FFCA, 0, 2);

        cur_test = "stall";
        w0 = wr_count;
        resp_ready = 1'b0;
        issue(0, SZ_W, 0, 32'h0100_0008, 0, 32'hBEEF_3344, 0, 2, 1'b1);
        for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h0100_0000;
        req_wdata = 32'h5555_5555;
        repeat (5) begin
            @(negedge clock);
            chk("stall_valid", {31'b0, resp_valid}, 32'h1);
            chk("stall_rdata", resp_rdata, 32'hBEEF_3344);
            chk("stall_ready", {31'b0, req_ready}, 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        chk("post_hs_valid", {31'b0, resp_valid}, 32'h0);
        chk("post_hs_ready", {31'b0, req_ready}, 32'h1);
        chk("stall_no_write", wr_count - w0, 32'd0);

        cur_test = "reset_in_wr";
        w0 = wr_count;
        issue(1, SZ_W, 0, 32'h0100_0010, 32'hFFFF_FFFF, 32'h0, 0, 2, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mrw", {31'b0, mem_read_write}, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", {31'b0, req_ready}, 32'h1);
        chk("rst_no_resp", {31'b0, resp_valid}, 32'h0);
        chk("rst_no_write", wr_count - w0, 32'd0);
        chk("rst_mem_word", mem_words[4], 32'h0);
        repeat (3) @(negedge clock);
        txn(0, SZ_W, 0, 32'h0100_0010, 0, 32'h0, 0, 2);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter STARTING_ADDR, default 'h01000000, byte address of mainmem location 0.
REQ-002 Parameter MEM_DEPTH_BYTES, default 'h0100000, mainmem size in bytes.
REQ-003 clock  in  1  single clock; all state changes on posedge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 req_valid  in  1  pipeline request present.
REQ-006 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-007 req_write  in  1  0 = load, 1 = store.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-justified.
REQ-012 resp_valid  out  1  response present.
REQ-013 resp_ready  in  1  consumer accepts response.
REQ-014 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-015 resp_error  out  1  misaligned, out-of-range or illegal-size request.
REQ-016 mem_address  out  32  to mainmem address; always word-aligned.
REQ-017 mem_data_in  out  32  to mainmem data_in.
REQ-018 mem_data_out  in  32  from mainmem data_out; combinational read of 4 bytes, little-endian.
REQ-019 mem_read_write  out  1  0 = READ, 1 = WRITE; mainmem commits all 4 bytes on posedge while 1.

Function
REQ-020 States IDLE, RD, WR, RESP; exactly one active.
REQ-021 Accept = req_valid && req_ready at posedge; request fields latched on accept.
REQ-022 Error = req_size==11, or addr not size-aligned (half: bit0; word: bits1:0), or addr < STARTING_ADDR, or addr > STARTING_ADDR+MEM_DEPTH_BYTES-4 after word alignment.
REQ-023 Error accept: IDLE->RESP, no memory cycle issued, resp_error=1, resp_rdata=0.
REQ-024 Load accept: IDLE->RD; in RD mem_address = addr & ~3, mem_read_write=0; at RD posedge mem_data_out registered; RD->RESP.
REQ-025 Word store accept: IDLE->WR; in WR mem_data_in = req_wdata, mem_read_write=1 for exactly one cycle; WR->RESP.
REQ-026 Byte/half store: IDLE->RD (capture word)->WR (captured word with selected lanes replaced by req_wdata[7:0] or [15:0] at byte offset addr[1:0])->RESP; untouched lanes written back unchanged.
REQ-027 Load extraction: byte lane addr[1:0], half lane addr[1]; extend per req_unsigned; word returned unmodified.
REQ-028 RESP: resp_valid=1, resp_rdata/resp_error held stable until resp_valid && resp_ready at posedge, then ->IDLE.
REQ-029 Latency accept-edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-030 req_ready=0 in RD, WR, RESP; no new request accepted until the cycle after the response handshake.
REQ-031 mem_read_write=1 only in WR and only when reset=0; 0 in every other state.
REQ-032 In IDLE and RESP, mem_address holds its last value and mem_data_in holds last value.
REQ-033 Highest legal word (STARTING_ADDR+MEM_DEPTH_BYTES-4) is legal; address wrap never occurs.

Reset
REQ-034 reset=1 at posedge: state->IDLE, resp_valid=0, resp_error=0, resp_rdata=0, mem_address=STARTING_ADDR, mem_data_in=0, latched request cleared.
REQ-035 While reset=1, req_ready=0 and mem_read_write=0, so reset in WR commits no write.
REQ-036 Reset mid-operation discards the request with no response; reset has priority over accept and response handshake in the same cycle.

Verification
REQ-037 Mem word 0x01000004 = 0x80FF7F01; load byte signed addr 0x01000006 -> resp_rdata 0xFFFFFFFF after 2 cycles, resp_error=0.
REQ-038 Same word; load half unsigned addr 0x01000006 -> resp_rdata 0x000080FF; load word -> 0x80FF7F01.
REQ-039 Store byte 0xAB to 0x01000005 over 0x80FF7F01 -> one write of 0x80FFAB01 to 0x01000004, resp_valid after 3 cycles, mem_read_write high exactly 1 cycle.
REQ-040 Load word at 0x01000002 and load at 0x00FFFFFC and size=11 -> resp_error=1 after 1 cycle, mem_read_write never 1, resp_rdata=0.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0, req_valid ignored; handshake -> IDLE next cycle.
REQ-042 Reset asserted during WR of word store -> memory word unchanged, no response, req_ready=1 cycle after reset deasserts.
